scandoubler_ctl: RTL and testbench

- Sequencer for a pair of one-line RAM buffers (bank 0, bank 1) that form the VGA scan doubler.
- Ping-pongs the banks: one bank is written with the current 15 kHz source line while the other bank is read out twice at 2x pixel rate.
- Drives each bank's clock-enables, write enable and address-counter resets, the output data mux select, and the doubled hsync/active timing.
- Sits between the Vector-06C video timing generator and the VGA output stage.

---
 rtl/scandoubler_pkg.sv | 23 ++
 rtl/scandoubler_port.sv | 67 ++++++
 rtl/scandoubler_ctl.sv | 155 +++++++++++++++
 tb/tb_scandoubler_ctl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scandoubler_pkg.sv
// Shared definitions for the VGA scan doubler sequencer.
//   LINE_PIXELS_DEFAULT : pixels per source line
//   BANK_AW             : width of the line-RAM address counter
//   bank_e              : line-RAM bank select encoding
//   seq_state_e         : pass sequencer states (used for both write and read passes)
package scandoubler_pkg;

  localparam int LINE_PIXELS_DEFAULT = 768;
  localparam int BANK_AW             = 10;

  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_e;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_CLR  = 2'd1,
    RD_RUN  = 2'd2,
    RD_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/scandoubler_port.sv
// One pass sequencer for a line-RAM port: a one-cycle clear, then one
// counted step per strobe until LINE_PIXELS steps have been taken.
//   clk, reset : clock, synchronous active-high reset
//   start      : begin a new pass (aborts any pass in progress)
//   step       : pixel strobe for this port
//   clr        : clear cycle of the pass (bank address counter reset)
//   running    : pass started and fewer than LINE_PIXELS steps taken;
//                a step is taken on cycles with running & step
module scandoubler_port
  import scandoubler_pkg::*;
#(
  parameter int LINE_PIXELS = LINE_PIXELS_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic step,
  output logic clr,
  output logic running
);

  localparam logic [BANK_AW:0] LIMIT = LINE_PIXELS[BANK_AW:0];

  seq_state_e       state, state_nxt;
  logic [BANK_AW:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr       = 1'b0;
    running   = 1'b0;
    unique case (state)
      RD_CLR: begin
        // a strobe landing on the clear cycle is deliberately dropped
        clr       = 1'b1;
        cnt_nxt   = '0;
        state_nxt = RD_RUN;
      end
      RD_RUN: begin
        if (cnt < LIMIT) begin
          running = 1'b1;
          if (step) cnt_nxt = cnt + 1'b1;
        end else begin
          state_nxt = RD_DONE;
        end
      end
      default: ;
    endcase
    // a new pass wins over everything and stops stepping in the same cycle
    if (start) begin
      state_nxt = RD_CLR;
      cnt_nxt   = cnt;
      running   = 1'b0;
    end
  end

endmodule

// File: rtl/scandoubler_ctl.sv
// Scan doubler sequencer: ping-pongs two one-line RAM banks. The bank being
// written takes the current 15 kHz source line while the other bank is read
// out twice at the 2x pixel rate.
//   clk, reset            : clock, synchronous active-high reset
//   hsync_in              : source hsync (clk-synchronous level)
//   ce_in / ce_out        : 1x source / 2x output pixel strobes
//   cewrN, wrenN, resetwrN: write counter enable, RAM write enable, counter clear
//   cerdN, resetrdN       : read counter enable, counter clear
//   rdsel                 : bank whose dout feeds VGA
//   pass                  : 0 = first read of the line, 1 = repeat
//   hsync_out, active_out : doubled hsync, valid-dout window
// All outputs are registered.
module scandoubler_ctl
  import scandoubler_pkg::*;
#(
  parameter int LINE_PIXELS   = LINE_PIXELS_DEFAULT,
  parameter int HSYNC_OUT_LEN = 56,
  parameter int PERIOD_W      = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic hsync_in,
  input  logic ce_in,
  input  logic ce_out,
  output logic cewr0,
  output logic cewr1,
  output logic wren0,
  output logic wren1,
  output logic resetwr0,
  output logic resetwr1,
  output logic cerd0,
  output logic cerd1,
  output logic resetrd0,
  output logic resetrd1,
  output logic rdsel,
  output logic pass,
  output logic hsync_out,
  output logic active_out
);

  localparam int                  WR         = 0;
  localparam int                  RD         = 1;
  localparam int                  HS_W       = $clog2(HSYNC_OUT_LEN + 1);
  localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

  logic                hs_d;
  logic                hs_rise;
  logic                seen_edge;   // a previous hs_rise exists to measure from
  bank_e               wrbank;
  logic [PERIOD_W-1:0] period_cnt;
  logic [PERIOD_W-1:0] period_prev;
  logic [PERIOD_W-1:0] half;
  logic                period_ok;
  logic                pass1_start;
  logic [HS_W-1:0]     hs_left;
  logic                act_d;

  logic [1:0] p_start, p_step, p_clr, p_run;
  logic       wr_ce, wr_adv, rd_ce;

  assign hs_rise = hsync_in & ~hs_d;
  assign half    = period_prev >> 1;

  // A saturated or zero period is not a real line; a tiny one leaves no room
  // for the repeat pass.
  assign period_ok = (period_prev != '0) && (period_prev != PERIOD_MAX) &&
                     (half >= PERIOD_W'(2));

  // hs_rise in the same cycle wins: the repeat is skipped for the new line.
  assign pass1_start = !hs_rise && !pass && period_ok && (period_cnt == half);

  assign p_start[WR] = hs_rise;
  assign p_step[WR]  = ce_in;
  assign p_start[RD] = hs_rise | pass1_start;
  assign p_step[RD]  = ce_out;

  scandoubler_port #(
    .LINE_PIXELS(LINE_PIXELS)
  ) u_port [1:0] (
    .clk    (clk),
    .reset  (reset),
    .start  (p_start),
    .step   (p_step),
    .clr    (p_clr),
    .running(p_run)
  );

  assign wr_adv = p_run[WR] & ce_in;
  assign wr_ce  = p_clr[WR] | wr_adv;
  assign rd_ce  = p_clr[RD] | (p_run[RD] & ce_out);

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_d        <= 1'b0;
      seen_edge   <= 1'b0;
      wrbank      <= BANK0;
      period_cnt  <= '0;
      period_prev <= '0;
      hs_left     <= '0;
      act_d       <= 1'b0;
      cewr0       <= 1'b0;
      cewr1       <= 1'b0;
      wren0       <= 1'b0;
      wren1       <= 1'b0;
      resetwr0    <= 1'b0;
      resetwr1    <= 1'b0;
      cerd0       <= 1'b0;
      cerd1       <= 1'b0;
      resetrd0    <= 1'b0;
      resetrd1    <= 1'b0;
      rdsel       <= 1'b0;
      pass        <= 1'b0;
      hsync_out   <= 1'b0;
      active_out  <= 1'b0;
    end else begin
      hs_d <= hsync_in;

      if (hs_rise) begin
        // the interval from reset to the first edge is not a line period
        period_prev <= seen_edge ? period_cnt : '0;
        period_cnt  <= '0;
        seen_edge   <= 1'b1;
        wrbank      <= (wrbank == BANK0) ? BANK1 : BANK0;
        rdsel       <= wrbank;
        pass        <= 1'b0;
      end else begin
        if (period_cnt != PERIOD_MAX) period_cnt <= period_cnt + 1'b1;
        if (pass1_start) pass <= 1'b1;
      end

      // wrbank/rdsel have already switched by the clear cycle, so the
      // bank gating below always targets the new line's banks.
      cewr0    <= wr_ce     && (wrbank == BANK0);
      cewr1    <= wr_ce     && (wrbank == BANK1);
      wren0    <= wr_adv    && (wrbank == BANK0);
      wren1    <= wr_adv    && (wrbank == BANK1);
      resetwr0 <= p_clr[WR] && (wrbank == BANK0);
      resetwr1 <= p_clr[WR] && (wrbank == BANK1);
      cerd0    <= rd_ce     && (rdsel == BANK0);
      cerd1    <= rd_ce     && (rdsel == BANK1);
      resetrd0 <= p_clr[RD] && (rdsel == BANK0);
      resetrd1 <= p_clr[RD] && (rdsel == BANK1);

      // extra stage covers the RAM read latency
      act_d      <= p_run[RD];
      active_out <= act_d;

      // hsync_out rises with the read clear and lasts HSYNC_OUT_LEN cycles
      hsync_out <= p_clr[RD] || (hs_left != '0);
      if (p_clr[RD])           hs_left <= HS_W'(HSYNC_OUT_LEN - 1);
      else if (hs_left != '0)  hs_left <= hs_left - 1'b1;
    end
  end

endmodule

// File: tb/tb_scandoubler_ctl.sv
// Scoreboard bench for scandoubler_ctl with LINE_PIXELS=8. Each source hsync
// edge pushes the expected write clear and read-pass starts; a negedge
// monitor pops them as the DUT produces them and checks per-pass counts.
module tb_scandoubler_ctl;

  localparam int LP    = 8;
  localparam int HSLEN = 56;
  localparam int PMAX  = 4095;

  typedef struct {
    int t;
    int bank;
    int pass;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic hsync_in = 1'b0;
  logic ce_in = 1'b0;
  logic ce_out = 1'b0;
  logic cewr0, cewr1, wren0, wren1, resetwr0, resetwr1;
  logic cerd0, cerd1, resetrd0, resetrd1;
  logic rdsel, pass, hsync_out, active_out;

  int cyc = 0;
  int force_cyc = -10;
  int n_chk = 0;
  int n_fail = 0;

  exp_t rq[$];
  exp_t wq[$];

  // model state (main process only)
  int have_prev = 0;
  int prev_p = 0;
  int wrbank_m = 0;

  // requests to the monitor
  logic zero_req = 1'b0;
  logic final_req = 1'b0;

  scandoubler_ctl #(
    .LINE_PIXELS  (LP),
    .HSYNC_OUT_LEN(HSLEN),
    .PERIOD_W     (12)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hsync_in  (hsync_in),
    .ce_in     (ce_in),
    .ce_out    (ce_out),
    .cewr0     (cewr0),
    .cewr1     (cewr1),
    .wren0     (wren0),
    .wren1     (wren1),
    .resetwr0  (resetwr0),
    .resetwr1  (resetwr1),
    .cerd0     (cerd0),
    .cerd1     (cerd1),
    .resetrd0  (resetrd0),
    .resetrd1  (resetrd1),
    .rdsel     (rdsel),
    .pass      (pass),
    .hsync_out (hsync_out),
    .active_out(active_out)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // pixel strobes; ce_in also forced high on each write clear cycle
  initial forever begin
    @(posedge clk);
    #1;
    ce_in  = (cyc % 4 == 0) || (cyc == force_cyc);
    ce_out = (cyc % 2 == 0);
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  int   in_pass = 0, pass_bank = 0, cerd_cnt = 0, act_cnt = 0, act_prev = 0;
  int   hs_prev = 0, hs_len = 0;
  int   wr_active = 0, wr_bank = 0, wren_cnt = 0;
  int   viol = 0;

  initial begin
    exp_t e;
    int   rb, wb;
    logic [13:0] outs;
    forever begin
      @(negedge clk);
      outs = {cewr0, cewr1, wren0, wren1, resetwr0, resetwr1, cerd0, cerd1,
              resetrd0, resetrd1, rdsel, pass, hsync_out, active_out};
      if (reset) begin
        in_pass = 0; cerd_cnt = 0; act_cnt = 0; act_prev = 0;
        hs_prev = 0; hs_len = 0; wr_active = 0; wren_cnt = 0;
      end else begin
        if (zero_req) chk("reset_outputs", int'(outs), 0);

        // read side
        if (resetrd0 || resetrd1) begin
          rb = resetrd1 ? 1 : 0;
          if (in_pass != 0) viol++;
          if (rq.size() == 0) chk("rd_start_unexpected", cyc, -1);
          else begin
            e = rq.pop_front();
            chk("rd_start_time", cyc, e.t);
            chk("rd_start_bank", rb, e.bank);
            chk("rd_start_pass", int'(pass), e.pass);
            chk("rd_start_rdsel", int'(rdsel), e.bank);
            chk("rd_start_cerd", int'(rb ? cerd1 : cerd0), 1);
            chk("rd_start_hsync", int'(hsync_out), 1);
          end
          in_pass = 1; pass_bank = rb; cerd_cnt = 0; act_cnt = 0;
        end else if (cerd0 || cerd1) begin
          if (in_pass != 0 && !(cerd0 && cerd1) && (cerd1 ? 1 : 0) == pass_bank)
            cerd_cnt++;
          else
            viol++;
        end
        if (active_out) begin
          if (in_pass != 0) act_cnt++;
          else viol++;
        end
        if (act_prev != 0 && !active_out && in_pass != 0) begin
          chk("rd_strobes", cerd_cnt, LP);
          chk("active_len_ok", int'(act_cnt == 2*LP - 1 || act_cnt == 2*LP), 1);
          in_pass = 0;
        end
        act_prev = active_out ? 1 : 0;

        if (hsync_out) hs_len++;
        else if (hs_prev != 0) begin
          chk("hsync_len", hs_len, HSLEN);
          hs_len = 0;
        end
        hs_prev = hsync_out ? 1 : 0;

        // write side
        if (resetwr0 || resetwr1) begin
          wb = resetwr1 ? 1 : 0;
          if (wr_active != 0) chk("wren_count", wren_cnt, LP);
          if (wq.size() == 0) chk("wr_clr_unexpected", cyc, -1);
          else begin
            e = wq.pop_front();
            chk("wr_clr_time", cyc, e.t);
            chk("wr_clr_bank", wb, e.bank);
            chk("wr_clr_cewr", int'(wb ? cewr1 : cewr0), 1);
            chk("wr_clr_wren", int'(wren0 | wren1), 0);
          end
          wr_active = 1; wr_bank = wb; wren_cnt = 0;
        end else begin
          if (wren0 || wren1) begin
            if (wr_active != 0 && !(wren0 && wren1) && (wren1 ? 1 : 0) == wr_bank &&
                (wr_bank ? cewr1 : cewr0))
              wren_cnt++;
            else
              viol++;
          end
          if ((wr_bank == 0 && cewr1) || (wr_bank == 1 && cewr0)) viol++;
        end
        if ((cewr0 && cerd0) || (cewr1 && cerd1)) viol++;

        if (final_req) begin
          chk("violations", viol, 0);
          chk("rd_queue_left", rq.size(), 0);
          chk("wr_queue_left", wq.size(), 0);
          chk("pass_open", in_pass, 0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic rise();
    int   p, pp, half, rdb;
    exp_t e;
    @(posedge clk);
    #1;
    hsync_in  = 1'b1;
    p         = cyc;
    force_cyc = p + 1;
    if (have_prev != 0) pp = (p - prev_p - 1 > PMAX) ? PMAX : p - prev_p - 1;
    else pp = 0;
    have_prev = 1;
    prev_p    = p;
    // a repeat pass that would start on or after this edge is pre-empted
    while (rq.size() > 0 && rq[rq.size()-1].t >= p + 2) void'(rq.pop_back());
    rdb      = wrbank_m;
    wrbank_m = 1 - wrbank_m;
    e.t = p + 2; e.bank = wrbank_m; e.pass = 0;
    wq.push_back(e);
    e.t = p + 2; e.bank = rdb; e.pass = 0;
    rq.push_back(e);
    half = pp / 2;
    if (pp != 0 && pp != PMAX && half >= 2) begin
      e.t = p + half + 3; e.bank = rdb; e.pass = 1;
      rq.push_back(e);
    end
  endtask

  task automatic line(input int len);
    rise();
    repeat (19) @(posedge clk);
    #1 hsync_in = 1'b0;
    repeat (len - 20) @(posedge clk);
  endtask

  task automatic model_reset();
    rq.delete();
    wq.delete();
    have_prev = 0;
    wrbank_m  = 0;
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    zero_req = 1'b1;
    @(negedge clk);
    #1 zero_req = 1'b0;
    repeat (20) @(posedge clk);

    line(400);   // first line after reset: no repeat pass
    line(400);
    line(400);
    line(200);   // next edge lands on the repeat-pass start cycle
    line(400);   // short previous period -> repeat after 100
    line(300);   // next edge arrives ~100 clk into the repeat pass
    line(4200);  // next line sees a saturated period
    line(400);   // repeat suppressed
    line(400);

    // reset in the middle of a line
    rise();
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    hsync_in = 1'b0;
    zero_req = 1'b1;
    @(negedge clk);
    #1 zero_req = 1'b0;
    repeat (30) @(posedge clk);

    line(400);   // period unknown again: pass 0 only
    line(400);
    repeat (300) @(posedge clk);

    #1 final_req = 1'b1;
    @(negedge clk);
    #1 final_req = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
